alu_result_stage: RTL and testbench
===================================

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 SHALL have parameter: WIDTH, 32, width of result buses.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  upstream ALU result valid.
REQ-005 SHALL have port: in_ready  output  1  stage can accept a result.
REQ-006 SHALL have port: in_result  input  WIDTH  result from the combinational ALU.
REQ-007 SHALL have port: in_sel  input  2  ALU op code producing in_result (0 add, 1 sub, 2 nand, 3 nor).
REQ-008 SHALL have port: out_valid  output  1  head entry valid.
REQ-009 SHALL have port: out_ready  input  1  downstream accepts head entry.
REQ-010 SHALL have port: out_result  output  WIDTH  head entry result.
REQ-011 SHALL have port: out_sel  output  2  head entry op code.
REQ-012 SHALL have port: out_zero  output  1  head result equals zero.
REQ-013 SHALL have port: out_neg  output  1  head result MSB (bit WIDTH-1).
REQ-014 SHALL have port: level  output  2  occupied entries, 0..2.

Function
REQ-015 SHALL be a 2-entry FIFO of {result, sel, zero, neg}; circular, 1-bit read and write pointers.
REQ-016 Push SHALL occur on a rising edge when in_valid && in_ready; pop when out_valid && out_ready.
REQ-017 in_ready SHALL equal (level != 2); no combinational path from out_ready to in_ready.
REQ-018 out_valid SHALL equal (level != 0); out_* SHALL be driven from the read-pointer entry, registered only.
REQ-019 Latency: result pushed at edge N SHALL be visible on out_* with out_valid=1 after edge N (one cycle).
REQ-020 Flags SHALL be computed at push time from in_result and stored with the entry, not recomputed at output.
REQ-021 Simultaneous push and pop: level unchanged; both pointers advance; order preserved.
REQ-022 Full (level=2) with pop: level becomes 1; in_ready stays 0 during that cycle; no push.
REQ-023 Empty (level=0): out_valid=0; out_ready ignored; pointers unchanged.
REQ-024 Pointer wrap: 1 to 0 on advance; entries SHALL exit strictly in push order.
REQ-025 out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 Contents of empty entries SHALL not change out_valid; out_result etc. may show stale data when out_valid=0.

Reset
REQ-027 rst_n low SHALL immediately clear pointers, level to 0, out_valid to 0, in_ready to 1.
REQ-028 Storage SHALL reset to zero, so out_result=0, out_sel=0, out_zero=0, out_neg=0 during reset.
REQ-029 Reset mid-operation SHALL discard all entries; first push after release behaves as from empty.

Configuration
REQ-030 Macro ALU_RES_FLAGS_EN defined: zero/neg flag computation and storage present, out_zero/out_neg per REQ-012/013.
REQ-031 Macro ALU_RES_FLAGS_EN undefined: flag storage not built; out_zero and out_neg ports remain, tied to 0; all other behaviour identical.

Verification
REQ-032 Reset, then single push in_result=0x00000005, sel=0 -> next cycle out_valid=1, out_result=0x00000005, out_zero=0, out_neg=0, level=1.
REQ-033 out_ready=0, push 0x00000000 then 0x80000000 -> level=2, in_ready=0, head 0x0 with out_zero=1; after pop head 0x80000000 with out_neg=1 (flags 0 if macro undefined).
REQ-034 level=1, push 0x11 and pop same cycle -> level stays 1, out_result=0x11 next cycle, pointers wrapped.
REQ-035 Full, out_ready=1, in_valid=1 held -> first cycle pops only (in_ready=0), level 1; next cycle push+pop, level 1.
REQ-036 level=2, assert rst_n=0 asynchronously mid-cycle -> out_valid=0, level=0, in_ready=1 without waiting for clk edge.
REQ-037 Random in_valid/out_ready for 1000 cycles -> output sequence equals input sequence, level never exceeds 2.

Source files
------------

// File: rtl/alu_result_stage.sv
// Two-entry result FIFO after the ALU: one cycle push-to-output, registered outputs, in_ready = not full.
// Zero/negative flags are captured at push time only when ALU_RES_FLAGS_EN is defined; otherwise tied low.
module alu_result_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [1:0]       in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [1:0]       out_sel,
  output logic             out_zero,
  output logic             out_neg,
  output logic [1:0]       level
);

`ifdef ALU_RES_FLAGS_EN
  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [1:0]       sel;
    logic             zero;
    logic             neg;
  } entry_t;
`else
  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [1:0]       sel;
  } entry_t;
`endif

  entry_t     mem [2];
  entry_t     in_entry;
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;

  // Ready depends only on stored occupancy, never on out_ready.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign level     = count;

  always_comb begin
    in_entry        = '0;
    in_entry.result = in_result;
    in_entry.sel    = in_sel;
`ifdef ALU_RES_FLAGS_EN
    in_entry.zero   = (in_result == '0);
    in_entry.neg    = in_result[WIDTH-1];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign out_result = mem[rd_ptr].result;
  assign out_sel    = mem[rd_ptr].sel;
`ifdef ALU_RES_FLAGS_EN
  assign out_zero   = mem[rd_ptr].zero;
  assign out_neg    = mem[rd_ptr].neg;
`else
  assign out_zero   = 1'b0;
  assign out_neg    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: directed vectors, then a random valid/ready soak.
`timescale 1ns/100ps
module tb_alu_result_stage;

`ifdef ALU_RES_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  typedef struct {
    logic [31:0] result;
    logic [1:0]  sel;
    logic        zero;
    logic        neg;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [1:0]  in_sel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [1:0]  out_sel;
  logic        out_zero;
  logic        out_neg;
  logic [1:0]  level;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  alu_result_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_sel(out_sel),
    .out_zero(out_zero), .out_neg(out_neg), .level(level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive 1 after the edge, record an accepted push 2 before the next edge.
  task automatic step(input logic iv, input logic [31:0] res, input logic [1:0] sel, input logic ordy);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_result = res;
    in_sel    = sel;
    out_ready = ordy;
    #7;
    if (in_valid && in_ready && rst_n) begin
      e.result = res;
      e.sel    = sel;
      e.zero   = FL && (res == 32'h0);
      e.neg    = FL && res[31];
      exp_q.push_back(e);
    end
  endtask

  // Monitor: occupancy after each edge, and output handshakes just before each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      chk("level_vs_model", {30'd0, level}, exp_q.size());
      if (level > 2'd2) chk("level_bound", {30'd0, level}, 32'd2);
      #7;
      if (out_valid && out_ready && rst_n) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("pop_result", out_result, e.result);
          chk("pop_sel", {30'd0, out_sel}, {30'd0, e.sel});
          chk("pop_zero", {31'd0, out_zero}, {31'd0, e.zero});
          chk("pop_neg", {31'd0, out_neg}, {31'd0, e.neg});
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_sel = '0; out_ready = 1'b0;
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_level", {30'd0, level}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_flags", {29'd0, out_sel, out_zero, out_neg}, 32'd0);
    #18;
    rst_n = 1'b1;

    // Single push of 5
    step(1'b1, 32'h5, 2'd0, 1'b0);
    step(1'b0, 32'h0, 2'd0, 1'b0);
    chk("single_out_valid", {31'd0, out_valid}, 32'd1);
    chk("single_result", out_result, 32'h5);
    chk("single_flags", {29'd0, out_sel, out_zero, out_neg}, 32'd0);
    chk("single_level", {30'd0, level}, 32'd1);
    step(1'b0, 32'h0, 2'd0, 1'b1);
    step(1'b0, 32'h0, 2'd0, 1'b0);
    chk("drained_level", {30'd0, level}, 32'd0);

    // Fill with zero and MSB-set results, stall, then pop
    step(1'b1, 32'h0, 2'd1, 1'b0);
    step(1'b1, 32'h8000_0000, 2'd2, 1'b0);
    step(1'b0, 32'h0, 2'd0, 1'b0);
    chk("full_level", {30'd0, level}, 32'd2);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_head", out_result, 32'h0);
    chk("full_head_zero", {31'd0, out_zero}, {31'd0, FL});
    chk("full_head_neg", {31'd0, out_neg}, 32'd0);
    step(1'b0, 32'h0, 2'd0, 1'b0);
    chk("stall_hold_result", out_result, 32'h0);
    chk("stall_hold_sel", {30'd0, out_sel}, 32'd1);
    step(1'b0, 32'h0, 2'd0, 1'b1);
    step(1'b0, 32'h0, 2'd0, 1'b0);
    chk("second_head", out_result, 32'h8000_0000);
    chk("second_neg", {31'd0, out_neg}, {31'd0, FL});
    chk("second_zero", {31'd0, out_zero}, 32'd0);
    chk("second_sel", {30'd0, out_sel}, 32'd2);
    chk("second_level", {30'd0, level}, 32'd1);

    // Simultaneous push and pop at level 1
    step(1'b1, 32'h11, 2'd3, 1'b1);
    step(1'b0, 32'h0, 2'd0, 1'b0);
    chk("pp_level", {30'd0, level}, 32'd1);
    chk("pp_result", out_result, 32'h11);

    // Full with out_ready and in_valid held
    step(1'b1, 32'h22, 2'd0, 1'b0);
    step(1'b1, 32'h33, 2'd1, 1'b1);
    chk("full_pop_in_ready", {31'd0, in_ready}, 32'd0);
    step(1'b1, 32'h33, 2'd1, 1'b1);
    chk("after_pop_level", {30'd0, level}, 32'd1);
    chk("after_pop_in_ready", {31'd0, in_ready}, 32'd1);
    step(1'b0, 32'h0, 2'd0, 1'b0);
    chk("held_level", {30'd0, level}, 32'd1);
    chk("held_head", out_result, 32'h33);

    // Asynchronous reset while full
    step(1'b1, 32'h44, 2'd0, 1'b0);
    step(1'b0, 32'h0, 2'd0, 1'b0);
    chk("pre_rst_level", {30'd0, level}, 32'd2);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_level", {30'd0, level}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_out_result", out_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'h55, 2'd2, 1'b0);
    step(1'b0, 32'h0, 2'd0, 1'b0);
    chk("post_rst_level", {30'd0, level}, 32'd1);
    chk("post_rst_head", out_result, 32'h55);
    step(1'b0, 32'h0, 2'd0, 1'b1);

    // Random soak
    for (int i = 0; i < 1000; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 2'd0, 1'b1);
    step(1'b0, 32'h0, 2'd0, 1'b0);
    chk("final_drained", exp_q.size(), 32'd0);
    chk("final_level", {30'd0, level}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
